// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with sequential shift-add multiply and restoring divide
// Divider datapath and DIV state are built only when MULDIV_DIV_EN is defined.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
`ifdef MULDIV_DIV_EN
    , S_DIV = 2'd3
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   w_hi, w_lo, opnd;
  logic               neg_lo;
  logic               accept, last_iter, is_mul_op, is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept    = op_valid && op_ready && !flush;
  assign is_mul_op = (funct == F_MULT) || (funct == F_MULTU);
  // Signed MULT/DIV have funct[0] = 0, unsigned variants have funct[0] = 1.
  assign is_signed = !funct[0];
  assign mag_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // w_hi accumulates partial products; w_lo holds the multiplier and collects product bits.
  assign mul_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
  assign prod_fix = neg_lo ? -{w_hi, w_lo} : {w_hi, w_lo};

`ifdef MULDIV_DIV_EN
  logic             neg_hi, is_div, is_div_op, div_ge;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_div_op = (funct == F_DIV) || (funct == F_DIVU);
  // w_hi is the partial remainder, w_lo shifts the dividend out and the quotient in.
  assign div_shift = {w_hi, w_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign quo_fix   = neg_lo ? -w_lo : w_lo;
  assign rem_fix   = neg_hi ? -w_hi : w_hi;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid && is_mul_op) state_nxt = S_MUL;
`ifdef MULDIV_DIV_EN
          else if (op_valid && is_div_op) state_nxt = S_DIV;
`endif
        end
        S_MUL: if (last_iter) state_nxt = S_FIX;
`ifdef MULDIV_DIV_EN
        S_DIV: if (last_iter) state_nxt = S_FIX;
`endif
        S_FIX: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    op_ready = (state == S_IDLE);
    busy     = !op_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      done   <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
`ifdef MULDIV_DIV_EN
      neg_hi <= 1'b0;
      is_div <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (funct == F_MTHI) hi_o <= src_a;
            if (funct == F_MTLO) lo_o <= src_a;
            if (is_mul_op) begin
              w_hi   <= '0;
              w_lo   <= mag_b;
              opnd   <= mag_a;
              neg_lo <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            end
`ifdef MULDIV_DIV_EN
            is_div <= is_div_op;
            if (is_div_op) begin
              w_hi   <= '0;
              w_lo   <= mag_a;
              opnd   <= mag_b;
              // Divide by zero keeps the all-ones quotient and restores src_a as remainder.
              neg_lo <= is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]) && (src_b != '0);
              neg_hi <= is_signed && src_a[WIDTH-1];
            end
`endif
          end
        end
        S_MUL: begin
          w_hi <= mul_sum[WIDTH:1];
          w_lo <= {mul_sum[0], w_lo[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          w_hi <= div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
          w_lo <= {w_lo[WIDTH-2:0], div_ge};
          cnt  <= cnt + CNT_W'(1);
        end
`endif
        S_FIX: begin
          if (!flush) begin
            done <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (is_div) begin
              hi_o <= rem_fix;
              lo_o <= quo_fix;
            end else
`endif
            begin
              hi_o <= prod_fix[2*WIDTH-1:WIDTH];
              lo_o <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - scoreboard bench for hilo_muldiv (adapts to MULDIV_DIV_EN)
module tb_hilo_muldiv;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst_n, op_valid, flush;
  logic [5:0]   funct;
  logic [W-1:0] src_a, src_b;
  logic         op_ready, busy, done;
  logic [W-1:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   mhi = '0, mlo = '0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
    .src_a(src_a), .src_b(src_b), .flush(flush), .op_ready(op_ready),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  function automatic bit div_built();
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] ohi,
                                           input logic [W-1:0] olo);
    logic signed [2*W-1:0] sa, sb, q, rm;
    logic [2*W-1:0] r;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    r  = {ohi, olo};
    if (f == F_MULT) r = sa * sb;
    else if (f == F_MULTU) r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else if (f == F_MTHI) r = {a, olo};
    else if (f == F_MTLO) r = {ohi, a};
    else if (div_built() && (f == F_DIV || f == F_DIVU)) begin
      if (b == '0) r = {a, {W{1'b1}}};
      else if (f == F_DIVU) r = {a % b, a / b};
      else begin
        q  = sa / sb;
        rm = sa % sb;
        r  = {rm[W-1:0], q[W-1:0]};
      end
    end
    return r;
  endfunction

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    int  nbusy;
    bit  seen, is_long;
    is_long = (f == F_MULT) || (f == F_MULTU) || (div_built() && (f == F_DIV || f == F_DIVU));
    exp_q.push_back(model(f, a, b, mhi, mlo));
    funct = f; src_a = a; src_b = b; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    nbusy = 0; seen = 1'b0;
    if (is_long) begin
      for (int i = 0; i < 4 * W && !seen; i++) begin
        if (done) seen = 1'b1;
        else begin
          if (busy) nbusy++;
          @(posedge clk); #1;
        end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL done_timeout funct=%b got no done, want done", f); end
      checks++;
      if (nbusy != W + 1) begin errors++; $display("FAIL busy_cycles funct=%b got %0d want %0d", f, nbusy, W + 1); end
      checks++;
      if (op_ready !== 1'b1) begin errors++; $display("FAIL ready_at_done funct=%b got %b want 1", f, op_ready); end
    end else begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL short_op funct=%b got busy=%b done=%b want 0/0", f, busy, done);
      end
    end
    e = exp_q.pop_front();
    mhi = e[2*W-1:W]; mlo = e[W-1:0];
    checks++;
    if (hi_o !== mhi || lo_o !== mlo) begin
      errors++;
      $display("FAIL result funct=%b a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", f, a, b, hi_o, lo_o, mhi, mlo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; funct = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hi_o !== '0 || lo_o !== '0 || op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_values got hi=%h lo=%h rdy=%b busy=%b done=%b want 0 0 1 0 0", hi_o, lo_o, op_ready, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    checks++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL mult_neg3x7 got hi=%h lo=%h want FFFFFFFF FFFFFFEB", hi_o, lo_o);
    end
    checks++;
    @(posedge clk); #1;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h1) begin
      errors++; $display("FAIL multu_max got hi=%h lo=%h want FFFFFFFE 00000001", hi_o, lo_o);
    end
    run_op(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h1) begin
      errors++; $display("FAIL mult_m1xm1 got hi=%h lo=%h want 0 1", hi_o, lo_o);
    end
  endtask

  task automatic test_divide();
    logic [W-1:0] hi0, lo0;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(F_DIV, 32'hFFFF_FFF0, 32'd0);
    run_op(F_MTHI, 32'hAAAA_0001, 32'd0);
    hi0 = mhi; lo0 = mlo;
    run_op(F_DIVU, 32'd5, 32'd0);
`ifdef MULDIV_DIV_EN
    checks++;
    if (hi_o !== 32'd5 || lo_o !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divu_by_zero got hi=%h lo=%h want 5 FFFFFFFF", hi_o, lo_o);
    end
`else
    checks++;
    if (hi_o !== hi0 || lo_o !== lo0) begin
      errors++; $display("FAIL div_disabled got hi=%h lo=%h want %h %h", hi_o, lo_o, hi0, lo0);
    end
`endif
  endtask

  task automatic test_flush();
    bit seen;
    run_op(F_MTHI, 32'h1234, 32'd0);
    run_op(F_MTLO, 32'h5678, 32'd0);
    checks++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
      errors++; $display("FAIL mthi_mtlo got hi=%h lo=%h want 1234 5678", hi_o, lo_o);
    end
    funct = F_MULT; src_a = 32'd3; src_b = 32'd4; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_accept got busy=%b want 1", busy); end
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_ready got rdy=%b busy=%b want 1 0", op_ready, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen || hi_o !== mhi || lo_o !== mlo) begin
      errors++; $display("FAIL flush_discard got done_seen=%b hi=%h lo=%h want 0 %h %h", seen, hi_o, lo_o, mhi, mlo);
    end
    funct = F_MULTU; src_a = 32'd5; src_b = 32'd5; op_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL flush_blocks_accept got busy=%b rdy=%b want 0 1", busy, op_ready);
    end
  endtask

  task automatic test_reset_midop();
    funct = F_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'd12345; op_valid = 1'b1;
    exp_q.push_back(model(F_MULTU, src_a, src_b, mhi, mlo));
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    mhi = '0; mlo = '0;
    checks++;
    if (hi_o !== '0 || lo_o !== '0 || busy !== 1'b0 || op_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL reset_midop got hi=%h lo=%h busy=%b rdy=%b done=%b want 0 0 0 1 0", hi_o, lo_o, busy, op_ready, done);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(F_MULTU, 32'd2, 32'd3);
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd6) begin
      errors++; $display("FAIL multu_after_reset got hi=%h lo=%h want 0 6", hi_o, lo_o);
    end
  endtask

  task automatic test_random();
    logic [5:0]   fl [5];
    logic [W-1:0] corner [4];
    logic [W-1:0] a, b;
    fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV; fl[3] = F_DIVU; fl[4] = 6'b100000;
    corner[0] = '0; corner[1] = 32'd1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      run_op(fl[$urandom_range(0, 4)], a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_divide();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
